dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory (`dmem`) between the processor's load/store path (port 0) and a debug/loader port (port 1). Port 0 has fixed priority. A wait counter guarantees that port 1 makes forward progress. The block tracks a one-cycle read latency, routes read data back to the issuing port, and rejects misaligned word accesses with an error pulse. It sits between `riscv_processor_top`'s memory stage and `dmem`.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Fixed-priority two-port arbiter in front of the single-port data memory.
// Port 0 wins by default; a wait counter forces a port-1 grant after STARVE_LIM lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_M0,
        GRANT_M1
    } grant_e;

    grant_e            sel;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              misaligned;
    logic              any_gnt;

    logic              rd_pend;
    logic              rd_owner;
    logic              rd_err;
    logic [3:0]        wait_cnt;

    // Grants are gated by reset so nothing leaks out while the block is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel = GRANT_NONE;
        if (rst) begin
            if (m1_req && wait_cnt == LIM) sel = GRANT_M1;
            else if (m0_req)               sel = GRANT_M0;
            else if (m1_req)               sel = GRANT_M1;
        end
    end

    always_comb begin
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        case (sel)
            GRANT_M0: begin
                g_we    = m0_we;
                g_addr  = m0_addr;
                g_wdata = m0_wdata;
            end
            GRANT_M1: begin
                g_we    = m1_we;
                g_addr  = m1_addr;
                g_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    assign m0_gnt     = (sel == GRANT_M0);
    assign m1_gnt     = (sel == GRANT_M1);
    assign any_gnt    = (sel != GRANT_NONE);
    assign misaligned = any_gnt && (g_addr[1:0] != 2'b00);

    // Misaligned accesses are accepted but never reach memory.
    assign mem_en    = any_gnt && !misaligned;
    assign mem_we    = g_we;
    assign mem_addr  = g_addr;
    assign mem_wdata = g_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            rd_err   <= 1'b0;
        end else if (any_gnt && (!g_we || misaligned)) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            rd_pend  <= 1'b1;
            rd_owner <= m1_gnt;
            rd_err   <= misaligned;
        end else begin
            rd_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend &&  rd_owner;
    assign m0_err    = m0_rvalid && rd_err;
    assign m1_err    = m1_rvalid && rd_err;
    assign m0_rdata  = (m0_rvalid && !rd_err) ? mem_rdata : '0;
    assign m1_rdata  = (m1_rvalid && !rd_err) ? mem_rdata : '0;

endmodule
